// File: rtl/share_mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals for the shared-memory arbiter.
// The arbiter uses the slave view; the requesters and memory use the master view.
interface share_mem_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 8,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*2-1:0]  req_len;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    beat;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;
  logic               mem_en;
  logic               mem_we;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic [DW-1:0]      mem_rdata;
  logic               busy;
  logic [1:0]         owner;

  modport slave (
    input  req, req_we, req_addr, req_len, req_wdata, mem_rdata,
    output gnt, beat, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, owner
  );

  modport master (
    output req, req_we, req_addr, req_len, req_wdata, mem_rdata,
    input  gnt, beat, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, owner
  );
endinterface

// File: rtl/share_mem_arbiter.sv
// Round-robin arbiter granting one requester at a time a 1..4 beat burst
// on a single memory port with 1-cycle read latency.
module share_mem_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 8,
  parameter int DW   = 32
) (
  input  logic clk,
  input  logic rst,
  share_mem_arbiter_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [1:0]    last_q, last_d;
  logic [1:0]    owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    len_q, len_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          rv_q, rv_d;
  logic [1:0]    rv_owner_q, rv_owner_d;

  logic          found;
  logic [1:0]    win;
  logic [1:0]    idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 2'(NREQ - 1);
      owner_q    <= 2'd0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      len_q      <= 2'd0;
      cnt_q      <= 2'd0;
      rv_q       <= 1'b0;
      rv_owner_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      rv_q       <= rv_d;
      rv_owner_q <= rv_owner_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    rv_d       = 1'b0;
    rv_owner_d = owner_q;
    found      = 1'b0;
    win        = 2'd0;
    idx        = 2'd0;
    case (state_q)
      IDLE: begin
        // search starts one past the last winner; k=4 wraps back to it
        for (int k = 1; k <= NREQ; k++) begin
          idx = last_q + 2'(k);
          if (!found && bus.req[idx]) begin
            found = 1'b1;
            win   = idx;
          end
        end
        if (found) begin
          state_d = BURST;
          owner_d = win;
          last_d  = win;
          we_d    = bus.req_we[win];
          addr_d  = bus.req_addr[int'(win)*AW +: AW];
          len_d   = bus.req_len[int'(win)*2 +: 2];
          cnt_d   = 2'd0;
        end
      end
      BURST: begin
        rv_d       = ~we_q;
        rv_owner_d = owner_q;
        if (cnt_q == len_q) begin
          state_d = IDLE;
          cnt_d   = 2'd0;
          owner_d = 2'd0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // outputs are forced quiet while rst is high, even before the reset edge lands
  always_comb begin
    bus.gnt       = '0;
    bus.beat      = '0;
    bus.rvalid    = '0;
    bus.rdata     = '0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.busy      = 1'b0;
    bus.owner     = 2'd0;
    if (!rst) begin
      if (state_q == BURST) begin
        bus.gnt[owner_q]  = (cnt_q == 2'd0);
        bus.beat[owner_q] = 1'b1;
        bus.mem_en        = 1'b1;
        bus.mem_we        = we_q;
        bus.mem_addr      = addr_q + AW'(cnt_q);
        bus.mem_wdata     = bus.req_wdata[int'(owner_q)*DW +: DW];
        bus.busy          = 1'b1;
        bus.owner         = owner_q;
      end
      if (rv_q) begin
        bus.rvalid[rv_owner_q] = 1'b1;
        bus.rdata              = bus.mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_share_mem_arbiter.sv
// Directed bench for share_mem_arbiter; memory model returns addr+0x80 one cycle after a read.
module tb_share_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  share_mem_arbiter_if #(.NREQ(4), .AW(8), .DW(32)) u_bus ();

  share_mem_arbiter #(.NREQ(4), .AW(8), .DW(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (u_bus.mem_en && !u_bus.mem_we)
      u_bus.mem_rdata <= {24'h0, u_bus.mem_addr} + 32'h80;

  logic [12:0] ctl;
  assign ctl = {u_bus.gnt, u_bus.beat, u_bus.mem_en, u_bus.mem_we, u_bus.busy, u_bus.owner};

  function automatic logic [12:0] exp_ctl(input logic [3:0] g, input logic [3:0] b,
                                          input logic en, input logic we,
                                          input logic bsy, input logic [1:0] own);
    return {g, b, en, we, bsy, own};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic we, input logic [7:0] a,
                         input logic [1:0] l, input logic [31:0] d);
    u_bus.req_we[i]          = we;
    u_bus.req_addr[i*8 +: 8] = a;
    u_bus.req_len[i*2 +: 2]  = l;
    u_bus.req_wdata[i*32 +: 32] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    u_bus.req = 4'b0;
    tick();
    tick();
    checks++;
    if ({ctl, u_bus.rvalid, u_bus.mem_addr, u_bus.mem_wdata, u_bus.rdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ctl=%h rvalid=%h addr=%h wdata=%h rdata=%h want all 0",
               ctl, u_bus.rvalid, u_bus.mem_addr, u_bus.mem_wdata, u_bus.rdata);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({ctl, u_bus.rvalid} !== '0) begin
      errors++;
      $display("FAIL idle_after_reset: got ctl=%h rvalid=%h want 0", ctl, u_bus.rvalid);
    end
  endtask

  task automatic test_single_write();
    set_req(1, 1'b1, 8'h10, 2'd0, 32'h12345678);
    u_bus.req = 4'b0010;
    tick();
    checks++;
    if (ctl !== exp_ctl(4'b0010, 4'b0010, 1'b1, 1'b1, 1'b1, 2'd1)) begin
      errors++;
      $display("FAIL single_write_ctl: got %h want %h", ctl,
               exp_ctl(4'b0010, 4'b0010, 1'b1, 1'b1, 1'b1, 2'd1));
    end
    checks++;
    if ({u_bus.mem_addr, u_bus.mem_wdata} !== {8'h10, 32'h12345678}) begin
      errors++;
      $display("FAIL single_write_bus: got addr=%h wdata=%h want 10/12345678",
               u_bus.mem_addr, u_bus.mem_wdata);
    end
    u_bus.req = 4'b0;
    tick();
    checks++;
    if ({ctl, u_bus.rvalid} !== '0) begin
      errors++;
      $display("FAIL single_write_end: got ctl=%h rvalid=%h want 0", ctl, u_bus.rvalid);
    end
  endtask

  task automatic test_burst_read();
    set_req(2, 1'b0, 8'h20, 2'd3, 32'h0);
    u_bus.req = 4'b0100;
    for (int k = 0; k <= 4; k++) begin
      tick();
      if (k < 4) begin
        checks++;
        if (ctl !== exp_ctl((k == 0) ? 4'b0100 : 4'b0000, 4'b0100, 1'b1, 1'b0, 1'b1, 2'd2)) begin
          errors++;
          $display("FAIL burst_read_ctl[%0d]: got %h want %h", k, ctl,
                   exp_ctl((k == 0) ? 4'b0100 : 4'b0000, 4'b0100, 1'b1, 1'b0, 1'b1, 2'd2));
        end
        checks++;
        if (u_bus.mem_addr !== 8'h20 + 8'(k)) begin
          errors++;
          $display("FAIL burst_read_addr[%0d]: got %h want %h", k, u_bus.mem_addr, 8'h20 + 8'(k));
        end
      end else begin
        checks++;
        if (ctl !== '0) begin
          errors++;
          $display("FAIL burst_read_end: got ctl=%h want 0", ctl);
        end
      end
      checks++;
      if (k == 0) begin
        if (u_bus.rvalid !== 4'b0) begin
          errors++;
          $display("FAIL burst_read_rv0: got rvalid=%h want 0", u_bus.rvalid);
        end
      end else if ({u_bus.rvalid, u_bus.rdata} !== {4'b0100, 32'hA0 + 32'(k - 1)}) begin
        errors++;
        $display("FAIL burst_read_rdata[%0d]: got rvalid=%h rdata=%h want 4/%h",
                 k, u_bus.rvalid, u_bus.rdata, 32'hA0 + 32'(k - 1));
      end
      if (k == 0) u_bus.req = 4'b0;
    end
    tick();
    checks++;
    if (u_bus.rvalid !== 4'b0) begin
      errors++;
      $display("FAIL burst_read_rv_tail: got rvalid=%h want 0", u_bus.rvalid);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] wa [4];
    wa = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    set_req(3, 1'b1, 8'hFE, 2'd3, 32'hCAFE0000);
    u_bus.req = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if ({ctl, u_bus.mem_addr, u_bus.rvalid} !==
          {exp_ctl((k == 0) ? 4'b1000 : 4'b0000, 4'b1000, 1'b1, 1'b1, 1'b1, 2'd3), wa[k], 4'b0}) begin
        errors++;
        $display("FAIL wrap[%0d]: got ctl=%h addr=%h rvalid=%h want addr=%h",
                 k, ctl, u_bus.mem_addr, u_bus.rvalid, wa[k]);
      end
      u_bus.req = 4'b0;
    end
    tick();
    checks++;
    if ({ctl, u_bus.rvalid} !== '0) begin
      errors++;
      $display("FAIL wrap_end: got ctl=%h rvalid=%h want 0", ctl, u_bus.rvalid);
    end
  endtask

  task automatic test_round_robin();
    int ord [5];
    ord = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'h30 + 8'(i), 2'd0, 32'h0);
    u_bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      checks++;
      if ({u_bus.gnt, u_bus.owner, u_bus.mem_addr} !==
          {4'b0001 << ord[g], 2'(ord[g]), 8'h30 + 8'(ord[g])}) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got gnt=%h owner=%0d addr=%h want requester %0d",
                 g, u_bus.gnt, u_bus.owner, u_bus.mem_addr, ord[g]);
      end
      if (g == 4) u_bus.req = 4'b0;
      tick();
      checks++;
      if ({u_bus.gnt, u_bus.busy, u_bus.mem_en} !== 6'b0) begin
        errors++;
        $display("FAIL rr_idle_gap[%0d]: got gnt=%h busy=%b en=%b want 0",
                 g, u_bus.gnt, u_bus.busy, u_bus.mem_en);
      end
    end
  endtask

  task automatic test_isolation();
    set_req(1, 1'b1, 8'h40, 2'd3, 32'h11110000);
    set_req(2, 1'b0, 8'h80, 2'd0, 32'h22220000);
    u_bus.req = 4'b0110;
    for (int k = 0; k < 4; k++) begin
      tick();
      u_bus.req_wdata[32 +: 32] = 32'h11110000 + 32'(k);
      set_req(2, k[0], 8'h80 + 8'(k * 7), 2'(k), 32'hDEAD0000 ^ 32'(k));
      #1;
      checks++;
      if ({ctl, u_bus.mem_addr, u_bus.mem_wdata} !==
          {exp_ctl((k == 0) ? 4'b0010 : 4'b0000, 4'b0010, 1'b1, 1'b1, 1'b1, 2'd1),
           8'h40 + 8'(k), 32'h11110000 + 32'(k)}) begin
        errors++;
        $display("FAIL isolation[%0d]: got ctl=%h addr=%h wdata=%h want addr=%h wdata=%h",
                 k, ctl, u_bus.mem_addr, u_bus.mem_wdata, 8'h40 + 8'(k), 32'h11110000 + 32'(k));
      end
      if (k == 0) u_bus.req[1] = 1'b0;
    end
    tick();
    checks++;
    if (ctl !== '0) begin
      errors++;
      $display("FAIL isolation_gap: got ctl=%h want 0", ctl);
    end
    set_req(2, 1'b1, 8'h90, 2'd0, 32'h22229999);
    tick();
    checks++;
    if ({ctl, u_bus.mem_addr, u_bus.mem_wdata} !==
        {exp_ctl(4'b0100, 4'b0100, 1'b1, 1'b1, 1'b1, 2'd2), 8'h90, 32'h22229999}) begin
      errors++;
      $display("FAIL isolation_next: got ctl=%h addr=%h wdata=%h want grant to 2 at 90",
               ctl, u_bus.mem_addr, u_bus.mem_wdata);
    end
    u_bus.req = 4'b0;
    tick();
  endtask

  task automatic test_reset_midburst();
    set_req(3, 1'b0, 8'h20, 2'd3, 32'h0);
    u_bus.req = 4'b1000;
    tick();
    checks++;
    if ({u_bus.gnt, u_bus.mem_addr} !== {4'b1000, 8'h20}) begin
      errors++;
      $display("FAIL abort_beat0: got gnt=%h addr=%h want 8/20", u_bus.gnt, u_bus.mem_addr);
    end
    u_bus.req = 4'b0;
    tick();
    checks++;
    if ({u_bus.mem_addr, u_bus.rvalid, u_bus.rdata} !== {8'h21, 4'b1000, 32'hA0}) begin
      errors++;
      $display("FAIL abort_beat1: got addr=%h rvalid=%h rdata=%h want 21/8/a0",
               u_bus.mem_addr, u_bus.rvalid, u_bus.rdata);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({ctl, u_bus.rvalid, u_bus.mem_addr, u_bus.mem_wdata, u_bus.rdata} !== '0) begin
      errors++;
      $display("FAIL during_reset: got ctl=%h rvalid=%h addr=%h rdata=%h want 0",
               ctl, u_bus.rvalid, u_bus.mem_addr, u_bus.rdata);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({ctl, u_bus.rvalid, u_bus.mem_addr, u_bus.mem_wdata, u_bus.rdata} !== '0) begin
      errors++;
      $display("FAIL after_reset: got ctl=%h rvalid=%h addr=%h rdata=%h want 0",
               ctl, u_bus.rvalid, u_bus.mem_addr, u_bus.rdata);
    end
    tick();
    checks++;
    if ({ctl, u_bus.rvalid} !== '0) begin
      errors++;
      $display("FAIL no_resume: got ctl=%h rvalid=%h want 0", ctl, u_bus.rvalid);
    end
    set_req(3, 1'b0, 8'h05, 2'd0, 32'h0);
    set_req(0, 1'b0, 8'h06, 2'd0, 32'h0);
    u_bus.req = 4'b1001;
    tick();
    checks++;
    if ({ctl, u_bus.mem_addr} !== {exp_ctl(4'b0001, 4'b0001, 1'b1, 1'b0, 1'b1, 2'd0), 8'h06}) begin
      errors++;
      $display("FAIL reset_priority: got ctl=%h addr=%h want grant to 0 at 06", ctl, u_bus.mem_addr);
    end
    u_bus.req = 4'b0;
    tick();
    checks++;
    if ({ctl, u_bus.rvalid, u_bus.rdata} !== {13'b0, 4'b0001, 32'h86}) begin
      errors++;
      $display("FAIL reset_priority_rdata: got ctl=%h rvalid=%h rdata=%h want 0/1/86",
               ctl, u_bus.rvalid, u_bus.rdata);
    end
  endtask

  initial begin
    rst             = 1'b1;
    u_bus.req       = '0;
    u_bus.req_we    = '0;
    u_bus.req_addr  = '0;
    u_bus.req_len   = '0;
    u_bus.req_wdata = '0;
    test_reset();
    test_single_write();
    test_burst_read();
    test_wrap();
    test_round_robin();
    test_isolation();
    test_reset_midburst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
